// File: rtl/i_decode_hz.sv
// MIPS ID stage: control decode, GPR file with WB bypass, sign extension, ID/EX register.
// Latency: 1 cycle from IF/ID inputs to ID/EX outputs; stall is combinational.
// Backpressure: stall holds PC and IF/ID for one cycle per load-use pair; flush squashes to a bubble.
// Optional load-use hazard detection is enabled by defining I_DECODE_HAZARD_EN.
module i_decode_hz #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       if_id_instr,
  input  logic [DATA_W-1:0] if_id_npc,
  input  logic              flush,
  input  logic              mem_wb_regwrite,
  input  logic [REG_AW-1:0] mem_wb_writereg,
  input  logic [DATA_W-1:0] mem_wb_writedata,
  output logic              stall,
  output logic [1:0]        wb,
  output logic [2:0]        m,
  output logic [3:0]        ex,
  output logic [DATA_W-1:0] npc,
  output logic [DATA_W-1:0] rdata1out,
  output logic [DATA_W-1:0] rdata2out,
  output logic [DATA_W-1:0] imm_ext,
  output logic [REG_AW-1:0] instrout_2016,
  output logic [REG_AW-1:0] instrout_1511
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [NREG];
  logic [REG_AW-1:0] rs, rt, rd;
  logic [5:0]        opcode;
  logic [8:0]        ctl_dec;
  logic [DATA_W-1:0] rd1, rd2, imm_dec;
  logic              wr_en;
  logic              bubble;

  assign opcode  = if_id_instr[31:26];
  assign rs      = REG_AW'(if_id_instr[25:21]);
  assign rt      = REG_AW'(if_id_instr[20:16]);
  assign rd      = REG_AW'(if_id_instr[15:11]);
  assign imm_dec = DATA_W'($signed(if_id_instr[IMM_W-1:0]));
  assign wr_en   = mem_wb_regwrite && (mem_wb_writereg != '0);

  // Opcode to {wb, m, ex}; unknown opcodes decode as a NOP.
  always_comb begin
    ctl_dec = 9'b0;
    case (opcode)
      6'h00:   ctl_dec = 9'b10_000_1100;
      6'h23:   ctl_dec = 9'b11_010_0001;
      6'h2B:   ctl_dec = 9'b00_001_0001;
      6'h04:   ctl_dec = 9'b00_100_0010;
      default: ctl_dec = 9'b0;
    endcase
  end

  // Register reads: $0 is hard zero, a same-cycle writeback wins over the array.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs != '0) rd1 = (wr_en && mem_wb_writereg == rs) ? mem_wb_writedata : regs[rs];
    if (rt != '0) rd2 = (wr_en && mem_wb_writereg == rt) ? mem_wb_writedata : regs[rt];
  end

  // Register file write port from MEM/WB; reset clears every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[mem_wb_writereg] <= mem_wb_writedata;
    end
  end

`ifdef I_DECODE_HAZARD_EN
  // Load in EX whose destination is a source of the instruction being decoded.
  assign stall = rst_n && m[1] && (instrout_2016 != '0) &&
                 ((instrout_2016 == rs) || (instrout_2016 == rt));
`else
  assign stall = 1'b0;
`endif

  assign bubble = flush || stall;

  // ID/EX pipeline register; a bubble only zeroes the control fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb            <= '0;
      m             <= '0;
      ex            <= '0;
      npc           <= '0;
      rdata1out     <= '0;
      rdata2out     <= '0;
      imm_ext       <= '0;
      instrout_2016 <= '0;
      instrout_1511 <= '0;
    end else begin
      {wb, m, ex}   <= bubble ? 9'b0 : ctl_dec;
      npc           <= if_id_npc;
      rdata1out     <= rd1;
      rdata2out     <= rd2;
      imm_ext       <= imm_dec;
      instrout_2016 <= rt;
      instrout_1511 <= rd;
    end
  end

endmodule

// File: tb/tb_i_decode_hz.sv
// Bench for i_decode_hz: directed steps then random traffic against a behavioural model.
// Latency: model predicts ID/EX outputs one edge after inputs are applied.
// Backpressure: bench holds IF/ID while the model predicts a stall.
module tb_i_decode_hz;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 16;
`ifdef I_DECODE_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   if_id_instr;
  logic [DW-1:0] if_id_npc;
  logic          flush;
  logic          mem_wb_regwrite;
  logic [AW-1:0] mem_wb_writereg;
  logic [DW-1:0] mem_wb_writedata;
  logic          stall;
  logic [1:0]    wb;
  logic [2:0]    m;
  logic [3:0]    ex;
  logic [DW-1:0] npc, rdata1out, rdata2out, imm_ext;
  logic [AW-1:0] instrout_2016, instrout_1511;

  i_decode_hz #(.DATA_W(DW), .REG_AW(AW), .IMM_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
    .flush(flush), .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_writereg(mem_wb_writereg),
    .mem_wb_writedata(mem_wb_writedata), .stall(stall), .wb(wb), .m(m), .ex(ex),
    .npc(npc), .rdata1out(rdata1out), .rdata2out(rdata2out), .imm_ext(imm_ext),
    .instrout_2016(instrout_2016), .instrout_1511(instrout_1511)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state: architectural registers and expected ID/EX contents.
  logic [DW-1:0] mreg [32];
  logic [1:0]    e_wb;
  logic [2:0]    e_m;
  logic [3:0]    e_ex;
  logic [DW-1:0] e_npc, e_r1, e_r2, e_imm;
  logic [4:0]    e_rt, e_rd;
  logic          last_stall;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s,
                                     input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [8:0] ctl(input logic [5:0] op);
    if (op == 6'h00) return 9'b10_000_1100;
    if (op == 6'h23) return 9'b11_010_0001;
    if (op == 6'h2B) return 9'b00_001_0001;
    if (op == 6'h04) return 9'b00_100_0010;
    return 9'b0;
  endfunction

  function automatic logic [DW-1:0] mread(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (mem_wb_regwrite && mem_wb_writereg == a) return mem_wb_writedata;
    return mreg[a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check stall mid-cycle, advance the model, then check ID/EX after the edge.
  task automatic tick();
    logic [4:0] s, t;
    logic       es;
    s  = if_id_instr[25:21];
    t  = if_id_instr[20:16];
    es = rst_n && HZ && e_m[1] && (e_rt != 0) && (e_rt == s || e_rt == t);
    @(negedge clk);
    chk("stall", {63'd0, stall}, {63'd0, es});
    last_stall = es;
    if (!rst_n) begin
      {e_wb, e_m, e_ex} = '0;
      e_npc = '0; e_r1 = '0; e_r2 = '0; e_imm = '0; e_rt = '0; e_rd = '0;
      for (int i = 0; i < 32; i++) mreg[i] = '0;
    end else begin
      {e_wb, e_m, e_ex} = (flush || es) ? 9'b0 : ctl(if_id_instr[31:26]);
      e_npc = if_id_npc;
      e_r1  = mread(s);
      e_r2  = mread(t);
      e_imm = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
      e_rt  = t;
      e_rd  = if_id_instr[15:11];
      if (mem_wb_regwrite && mem_wb_writereg != 0) mreg[mem_wb_writereg] = mem_wb_writedata;
    end
    @(posedge clk);
    #1;
    chk("wb",   64'(wb),            64'(e_wb));
    chk("m",    64'(m),             64'(e_m));
    chk("ex",   64'(ex),            64'(e_ex));
    chk("npc",  64'(npc),           64'(e_npc));
    chk("rd1",  64'(rdata1out),     64'(e_r1));
    chk("rd2",  64'(rdata2out),     64'(e_r2));
    chk("imm",  64'(imm_ext),       64'(e_imm));
    chk("rt",   64'(instrout_2016), 64'(e_rt));
    chk("rdf",  64'(instrout_1511), 64'(e_rd));
  endtask

  initial begin
    logic [5:0] op;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    {e_wb, e_m, e_ex} = '0;
    e_npc = '0; e_r1 = '0; e_r2 = '0; e_imm = '0; e_rt = '0; e_rd = '0;
    last_stall = 1'b0;

    // Reset with random instructions and a write that must be ignored.
    rst_n = 1'b0; flush = 1'b0;
    if_id_instr = $urandom; if_id_npc = $urandom;
    mem_wb_regwrite = 1'b1; mem_wb_writereg = 5'd3; mem_wb_writedata = $urandom;
    tick();
    if_id_instr = $urandom;
    tick();
    chk("rst_wb", 64'(wb), 64'd0);
    chk("rst_m", 64'(m), 64'd0);

    // Registers read zero after reset.
    rst_n = 1'b1; mem_wb_regwrite = 1'b0;
    if_id_instr = mk(6'h00, 5'd1, 5'd3, 16'h0820); if_id_npc = 32'h0000_0004;
    tick();
    chk("rst_rd1", 64'(rdata1out), 64'd0);
    chk("rst_rd2", 64'(rdata2out), 64'd0);

    // Write $5, then read it back through an R-type.
    if_id_instr = mk(6'h3F, 5'd0, 5'd0, 16'h0);
    mem_wb_regwrite = 1'b1; mem_wb_writereg = 5'd5; mem_wb_writedata = 32'hDEAD_BEEF;
    tick();
    mem_wb_regwrite = 1'b0;
    if_id_instr = mk(6'h00, 5'd5, 5'd0, 16'h1820);
    tick();
    chk("wr_rd1", 64'(rdata1out), 64'hDEAD_BEEF);
    chk("wr_rd2", 64'(rdata2out), 64'd0);
    chk("wr_wb", 64'(wb), 64'(2'b10));
    chk("wr_ex", 64'(ex), 64'(4'b1100));

    // Same-cycle bypass, and a write to $0 is never visible.
    mem_wb_regwrite = 1'b1; mem_wb_writereg = 5'd7; mem_wb_writedata = 32'h1234_5678;
    if_id_instr = mk(6'h00, 5'd7, 5'd5, 16'h2020);
    tick();
    chk("byp_rd1", 64'(rdata1out), 64'h1234_5678);
    mem_wb_writereg = 5'd0; mem_wb_writedata = 32'hFFFF_FFFF;
    if_id_instr = mk(6'h00, 5'd0, 5'd0, 16'h2020);
    tick();
    chk("r0_rd1", 64'(rdata1out), 64'd0);

    // Load-use pair: lw $8 followed by add using $8.
    mem_wb_regwrite = 1'b0;
    if_id_instr = mk(6'h23, 5'd0, 5'd8, 16'h0004);
    tick();
    if_id_instr = mk(6'h00, 5'd8, 5'd9, 16'h5020);
    tick();
`ifdef I_DECODE_HAZARD_EN
    chk("lu_bub_wb", 64'(wb), 64'd0);
    chk("lu_bub_m", 64'(m), 64'd0);
    chk("lu_bub_ex", 64'(ex), 64'd0);
    tick();
`endif
    chk("lu_add_wb", 64'(wb), 64'(2'b10));
    chk("lu_drop", 64'(stall), 64'd0);

    // Flushed lw with a negative immediate.
    flush = 1'b1;
    if_id_instr = mk(6'h23, 5'd1, 5'd2, 16'hFFFC);
    tick();
    chk("fl_wb", 64'(wb), 64'd0);
    chk("fl_m", 64'(m), 64'd0);
    chk("fl_ex", 64'(ex), 64'd0);
    chk("fl_imm", 64'(imm_ext), 64'hFFFF_FFFC);
    flush = 1'b0;

    // Reset asserted while a load-use stall is pending.
    if_id_instr = mk(6'h23, 5'd0, 5'd8, 16'h0000);
    tick();
    if_id_instr = mk(6'h00, 5'd8, 5'd8, 16'h0020);
    #1;
    chk("mr_pre", 64'(stall), 64'(HZ));
    rst_n = 1'b0;
    tick();
    chk("mr_wb", 64'(wb), 64'd0);
    chk("mr_rd1", 64'(rdata1out), 64'd0);
    rst_n = 1'b1;

    // Random traffic over a few registers so hazards and bypasses are frequent.
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        case ($urandom_range(0, 4))
          0: op = 6'h00;
          1: op = 6'h23;
          2: op = 6'h2B;
          3: op = 6'h04;
          default: op = 6'($urandom);
        endcase
        if_id_instr = mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
        if_id_npc   = $urandom;
      end
      flush            = ($urandom_range(0, 9) == 0);
      rst_n            = ($urandom_range(0, 59) != 0);
      mem_wb_regwrite  = $urandom_range(0, 1);
      mem_wb_writereg  = 5'($urandom_range(0, 7));
      mem_wb_writedata = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/i_decode_hz.md
Name: i_decode_hz

Overview:
- Parametrised next-generation MIPS ID (decode) stage.
- Contains the opcode control decoder, a general-purpose register file with write-through bypass, an immediate sign-extender, and the ID/EX pipeline register.
- Adds load-use hazard detection with stall/bubble insertion and a branch flush input.
- Sits between the IF/ID register and the EX stage. WB-stage write port comes from MEM/WB.

Parameters:
- DATA_W, 32, datapath width of register file, NPC and immediate output.
- REG_AW, 5, register address width; register count = 2**REG_AW.
- IMM_W, 16, immediate field width (Instr[IMM_W-1:0]); must satisfy IMM_W <= DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- if_id_instr  in  32  instruction from IF/ID.
- if_id_npc  in  DATA_W  next PC from IF/ID.
- flush  in  1  branch taken; squash the instruction being decoded.
- mem_wb_regwrite  in  1  writeback enable.
- mem_wb_writereg  in  REG_AW  writeback register address.
- mem_wb_writedata  in  DATA_W  writeback data.
- stall  out  1  combinational; high = hold PC and IF/ID.
- wb  out  2  {RegWrite, MemToReg}.
- m  out  3  {Branch, MemRead, MemWrite}.
- ex  out  4  {RegDst, ALUOp1, ALUOp0, ALUSrc}.
- npc  out  DATA_W  registered NPC.
- rdata1out, rdata2out  out  DATA_W  registered rs/rt data.
- imm_ext  out  DATA_W  registered sign-extended immediate.
- instrout_2016  out  REG_AW  registered rt field.
- instrout_1511  out  REG_AW  registered rd field.

Behaviour:
- Reset:
  - When rst_n=0 at a rising edge, all ID/EX outputs clear to 0 and all registers in the register file clear to 0.
  - stall is 0 while rst_n=0.
- Control decode, on opcode = instr[31:26], as {wb, m, ex}:
  - 0x00 R-type → 10, 000, 1100.
  - 0x23 lw → 11, 010, 0001.
  - 0x2B sw → 00, 001, 0001.
  - 0x04 beq → 00, 100, 0010.
  - Any other opcode → all zero (NOP).
- Register file:
  - rs = instr[25:21] and rt = instr[20:16], truncated or zero-extended to REG_AW.
  - Write occurs at the rising edge when mem_wb_regwrite=1 and mem_wb_writereg != 0.
  - Register 0 always reads 0.
  - Reads are combinational.
  - Bypass: if mem_wb_regwrite=1, the address is nonzero, and the address matches rs (or rt), the read returns mem_wb_writedata in the same cycle.
- Sign extension: imm_ext = {(DATA_W-IMM_W){instr[IMM_W-1]}, instr[IMM_W-1:0]}.
- Hazard detection:
  - stall = m[1] & (instrout_2016 != 0) & (instrout_2016 == rs | instrout_2016 == rt), where m[1] is the registered ID/EX MemRead.
  - Compare only the REG_AW-bit fields.
- ID/EX register, updated every rising edge:
  - If flush=1 or stall=1: wb, m and ex load 0 (bubble). Data fields (npc, rdata, imm, reg fields) still load their current values, which are don't-care for a bubble.
  - Otherwise all fields load the decoded values.
  - Latency: 1 cycle from IF/ID input to ID/EX output.
- Simultaneous events:
  - flush with stall → bubble, and stall stays asserted as computed.
  - Writeback to the rs register during a stall cycle → the bypass value is used when the instruction re-decodes.
  - Reset overrides flush, stall and writes.
- Stall duration: exactly one cycle per load-use pair. After the bubble, m[1]=0, so stall drops.

Optional Feature:
- Macro: I_DECODE_HAZARD_EN.
- Defined: hazard detection as above.
- Undefined: stall is tied to 0; only flush produces bubbles; hazard comparators are not instantiated.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random instr → all outputs 0, stall=0. Reading $1 afterwards → 0.
- Write then read: write $5=0xDEADBEEF. Next cycle decode R-type rs=5, rt=0 → rdata1out=0xDEADBEEF, rdata2out=0, wb=10, ex=1100.
- Bypass: same-cycle write $7=0x12345678 while decoding rs=7 → rdata1out=0x12345678 one cycle later. Write to $0 → reads 0.
- Load-use: lw rt=$8, then add rs=$8 → stall=1 for exactly one cycle; next outputs wb/m/ex=0. After re-decode, add controls appear (wb=10).
- Flush: decode lw with flush=1 → wb=0, m=0, ex=0, stall=0. Immediate 0xFFFC → imm_ext=0xFFFFFFFC.
- Mid-operation reset: assert rst_n=0 during a stall cycle → next edge outputs 0 and stall=0.
